// File: rtl/mips_mem_pkg.sv
// Shared types and address decode for the MIPS memory responders.
// Used by the data-side responder and later the instruction-side one.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] word;
    logic        in_range;
  } dmem_dec_t;

  // Word offset from base plus range flag; caller truncates the offset.
  function automatic dmem_dec_t addr_to_idx(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    dmem_dec_t   r;
    logic [31:0] off;
    off        = addr - base;
    r.word     = off / WORD_BYTES;
    r.in_range = (addr >= base) && (r.word < depth);
    return r;
  endfunction

endpackage

// File: rtl/mips_mem_wait_ctrl.sv
// Wait-state controller: stalls the CPU for LATENCY cycles per access
// and strobes latch (request accepted) and respond (access completes).
module mips_mem_wait_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  output logic cpu_clk_enable_o,
  output logic busy_o,
  output logic latch_o,
  output logic respond_o
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cpu_clk_enable_o = 1'b1;
    busy_o           = 1'b0;
    latch_o          = 1'b0;
    respond_o        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          cpu_clk_enable_o = !req_i;
          if (req_i) begin
            latch_o = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = (LATENCY > 1) ? WAIT : RESPOND;
          end
        end
        WAIT: begin
          cpu_clk_enable_o = 1'b0;
          busy_o           = 1'b1;
          cnt_d            = cnt_q - CNT_W'(1);
          if (cnt_d == '0) state_d = RESPOND;
        end
        RESPOND: begin
          respond_o = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the Harvard MIPS CPU with programmable wait states.
// Define MIPS_DMEM_FAULT_EN for the sticky fault flag and fault_addr_q capture.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        cpu_clk_enable,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;

`ifdef MIPS_DMEM_FAULT_EN
  logic        acc_done;
  logic        acc_bad;
  logic [31:0] acc_addr;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  if (LATENCY == 0) begin : g_l0
    dmem_dec_t dec;
    assign dec = addr_to_idx(data_address, ADDR_BASE, DEPTH_WORDS);

    always_comb begin
      cpu_clk_enable = 1'b1;
      busy           = 1'b0;
      wr_en          = !reset && data_write && dec.in_range;
      wr_idx         = IDX_W'(dec.word);
      wr_data        = data_writedata;
      data_readdata  = '0;
      if (!reset && data_read && !data_write && dec.in_range)
        data_readdata = mem_q[IDX_W'(dec.word)];
    end

`ifdef MIPS_DMEM_FAULT_EN
    assign acc_done = !reset && (data_read || data_write);
    assign acc_addr = data_address;
    assign acc_bad  = !dec.in_range || (|data_address[1:0])
                   || (data_read && data_write);
`endif
  end else begin : g_lat
    logic        latch;
    logic        respond;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    dmem_dec_t   ldec;

    mips_mem_wait_ctrl #(
      .LATENCY (LATENCY)
    ) u_wait (
      .clk              (clk),
      .reset            (reset),
      .req_i            (data_read | data_write),
      .cpu_clk_enable_o (cpu_clk_enable),
      .busy_o           (busy),
      .latch_o          (latch),
      .respond_o        (respond)
    );

    // Latched copy is authoritative once the CPU is stalled.
    always_ff @(posedge clk) begin
      if (reset) begin
        addr_q  <= '0;
        wdata_q <= '0;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
      end else if (latch) begin
        addr_q  <= data_address;
        wdata_q <= data_writedata;
        rd_q    <= data_read;
        wr_q    <= data_write;
      end
    end

    assign ldec = addr_to_idx(addr_q, ADDR_BASE, DEPTH_WORDS);

    always_comb begin
      wr_en         = respond && wr_q && ldec.in_range;
      wr_idx        = IDX_W'(ldec.word);
      wr_data       = wdata_q;
      data_readdata = '0;
      if (respond && rd_q && !wr_q && ldec.in_range)
        data_readdata = mem_q[IDX_W'(ldec.word)];
    end

`ifdef MIPS_DMEM_FAULT_EN
    assign acc_done = respond;
    assign acc_addr = addr_q;
    assign acc_bad  = !ldec.in_range || (|addr_q[1:0]) || (rd_q && wr_q);
`endif
  end

`ifdef MIPS_DMEM_FAULT_EN
  logic        fault_q;
  logic [31:0] fault_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (acc_done && acc_bad && !fault_q) begin
      fault_q      <= 1'b1;
      fault_addr_q <= acc_addr;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
